// File: rtl/branch_resolve.sv
// Resolves B/BR against the flag register; redirect/br_done 2 edges after accept, +1 per flag-hazard wait cycle.
// Only one branch in flight: br_ready drops until resolved and stall holds the front end. BR_STATS_EN adds taken/total counters.
module branch_resolve #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic             br_is_reg,
    input  logic [2:0]       ccc,
    input  logic [IMM_W-1:0] imm,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic [PC_W-1:0]  rs_data,
    input  logic [2:0]       flag,
    input  logic             flag_wr_pending,
    input  logic             flush,
    output logic             stall,
    output logic             redirect,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             br_done,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] total_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESOLVE} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             resolve;
    logic             taken;
    logic             is_reg_q;
    logic [2:0]       ccc_q;
    logic [IMM_W-1:0] imm_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  rs_q;
    logic [PC_W-1:0]  imm_ext;
    logic [PC_W-1:0]  target;
    logic             flag_z, flag_v, flag_n;

    assign br_ready = (state == IDLE);
    assign accept   = br_valid & br_ready & ~flush;
    assign stall    = (state != IDLE) | (br_valid & flag_wr_pending & (state == IDLE));

    assign {flag_z, flag_v, flag_n} = flag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        resolve   = 1'b0;
        case (state)
            IDLE:    if (accept) state_nxt = flag_wr_pending ? WAIT : RESOLVE;
            WAIT:    if (!flag_wr_pending) state_nxt = RESOLVE;
            RESOLVE: begin
                state_nxt = IDLE;
                resolve   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // A flush kills the branch wherever it is, including the resolve cycle.
        if (flush) begin
            state_nxt = IDLE;
            resolve   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_reg_q <= 1'b0;
            ccc_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rs_q     <= '0;
        end else if (accept) begin
            is_reg_q <= br_is_reg;
            ccc_q    <= ccc;
            imm_q    <= imm;
            pc_q     <= pc_plus2;
            rs_q     <= rs_data;
        end
    end

    // Condition is evaluated on the live flag input, which is settled once no write is pending.
    always_comb begin
        taken = 1'b0;
        case (ccc_q)
            3'b000: taken = ~flag_z;
            3'b001: taken = flag_z;
            3'b010: taken = ~flag_z & ~flag_n;
            3'b011: taken = flag_n;
            3'b100: taken = flag_z | ~flag_n;
            3'b101: taken = flag_z | flag_n;
            3'b110: taken = flag_v;
            default: taken = 1'b1;
        endcase
    end

    assign imm_ext = {{(PC_W-IMM_W){imm_q[IMM_W-1]}}, imm_q};
    assign target  = is_reg_q ? rs_q : (pc_q + {imm_ext[PC_W-2:0], 1'b0});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            br_done     <= 1'b0;
        end else begin
            redirect <= resolve & taken;
            br_done  <= resolve;
            if (resolve & taken) redirect_pc <= target;
        end
    end

`ifdef BR_STATS_EN
    logic [CNT_W-1:0] taken_q, total_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q <= '0;
            total_q <= '0;
        end else begin
            if (resolve && total_q != {CNT_W{1'b1}}) total_q <= total_q + 1'b1;
            if (resolve && taken && taken_q != {CNT_W{1'b1}}) taken_q <= taken_q + 1'b1;
        end
    end

    assign taken_cnt = taken_q;
    assign total_cnt = total_q;
`else
    assign taken_cnt = '0;
    assign total_cnt = '0;
`endif

endmodule
